layer2_mac_sequencer: RTL and testbench

Controller that sequences the softmax-layer multiply-accumulate store (`multStore`) through one inference pass. When started, it loads the bias registers by pulsing clear and bias-write together. It then walks the hidden-activation buffer and the layer-2 weight memory one input index per cycle, feeding each activation/weight-row pair to `multStore`, and signals completion when the accumulated sums are final. It sits between the top-level inference FSM and `multStore`, and owns the read port of both memories during a pass.

---
 rtl/layer2_mac_sequencer.sv | 125 ++++++++++++
 tb/tb_layer2_mac_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/layer2_mac_sequencer.sv
// Sequences one layer-2 inference pass into multStore: bias load, one read per
// input index, a drain cycle for the last returned pair, then a done pulse.
module layer2_mac_sequencer #(
  parameter int NUM_INPUTS                = 16,
  parameter int ADDR_WIDTH                = 4,
  parameter int LAYER_2_IN_BIT_WIDTH      = 8,
  parameter int LAYER_2_WEIGHTS_BIT_WIDTH = 8,
  parameter int SOFTMAX_NODES             = 10
) (
  input  logic                                                 clk,
  input  logic                                                 clr,
  input  logic                                                 start,
  output logic                                                 busy,
  output logic                                                 done,
  output logic                                                 rdEn,
  output logic [ADDR_WIDTH-1:0]                                rdAddr,
  input  logic [LAYER_2_IN_BIT_WIDTH-1:0]                      inData,
  input  logic [SOFTMAX_NODES*LAYER_2_WEIGHTS_BIT_WIDTH-1:0]   weightData,
  output logic [LAYER_2_IN_BIT_WIDTH-1:0]                      layer2In,
  output logic [SOFTMAX_NODES*LAYER_2_WEIGHTS_BIT_WIDTH-1:0]   weightsOut,
  output logic                                                 macClr,
  output logic                                                 macBiasWriteEnable
);

  localparam int ROW_W = SOFTMAX_NODES * LAYER_2_WEIGHTS_BIT_WIDTH;

  // Last index is found by compare so a full 2^ADDR_WIDTH pass never wraps.
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_INPUTS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;

  logic                  r_busy;
  logic                  r_done;
  logic                  r_rdEn;
  logic [ADDR_WIDTH-1:0] r_rdAddr;
  logic                  r_macClr;
  logic                  r_macBiasWe;
  logic                  r_fwdValid;

  // Next-state and next read index; r_rdAddr doubles as the index counter.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = {ADDR_WIDTH{1'b0}};
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_LOAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD: begin
        w_state_nxt = S_RUN;
        w_addr_nxt  = {ADDR_WIDTH{1'b0}};
      end
      S_RUN: begin
        if (r_rdAddr == LAST_IDX) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_RUN;
          w_addr_nxt  = r_rdAddr + ADDR_WIDTH'(1'b1);
        end
      end
      S_DRAIN: begin
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          w_state_nxt = S_LOAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register; outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rdEn      <= 1'b0;
      r_rdAddr    <= {ADDR_WIDTH{1'b0}};
      r_macClr    <= 1'b0;
      r_macBiasWe <= 1'b0;
      r_fwdValid  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_busy      <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_RUN) ||
                     (w_state_nxt == S_DRAIN);
      r_done      <= (w_state_nxt == S_DONE);
      r_rdEn      <= (w_state_nxt == S_RUN);
      r_rdAddr    <= w_addr_nxt;
      r_macClr    <= (w_state_nxt == S_LOAD);
      r_macBiasWe <= (w_state_nxt == S_LOAD);
      r_fwdValid  <= r_rdEn;
    end
  end

  assign busy               = r_busy;
  assign done               = r_done;
  assign rdEn               = r_rdEn;
  assign rdAddr             = r_rdAddr;
  assign macClr             = r_macClr;
  assign macBiasWriteEnable = r_macBiasWe;

  // multStore accumulates every edge, so non-data cycles must present zero.
  assign layer2In   = r_fwdValid ? inData     : {LAYER_2_IN_BIT_WIDTH{1'b0}};
  assign weightsOut = r_fwdValid ? weightData : {ROW_W{1'b0}};

endmodule

// File: tb/tb_layer2_mac_sequencer.sv
// Directed/random bench for layer2_mac_sequencer with a memory model and a
// multStore-style accumulator; expectations come from the pass timeline and arrays.
module tb_layer2_mac_sequencer;

  localparam int N     = 16;
  localparam int AW    = 4;
  localparam int IW    = 3;
  localparam int WW    = 3;
  localparam int NODES = 2;
  localparam int BW    = 6;

  logic                  clk = 1'b0;
  logic                  clr;
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  rdEn;
  logic [AW-1:0]         rdAddr;
  logic [IW-1:0]         inData;
  logic [NODES*WW-1:0]   weightData;
  logic [IW-1:0]         layer2In;
  logic [NODES*WW-1:0]   weightsOut;
  logic                  macClr;
  logic                  macBiasWriteEnable;

  logic [IW-1:0]         act  [N];
  logic [NODES*WW-1:0]   wrow [N];
  logic [NODES*BW-1:0]   bias;
  logic [BW-1:0]         acc  [NODES];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  layer2_mac_sequencer #(
    .NUM_INPUTS(N),
    .ADDR_WIDTH(AW),
    .LAYER_2_IN_BIT_WIDTH(IW),
    .LAYER_2_WEIGHTS_BIT_WIDTH(WW),
    .SOFTMAX_NODES(NODES)
  ) u_dut (
    .clk(clk),
    .clr(clr),
    .start(start),
    .busy(busy),
    .done(done),
    .rdEn(rdEn),
    .rdAddr(rdAddr),
    .inData(inData),
    .weightData(weightData),
    .layer2In(layer2In),
    .weightsOut(weightsOut),
    .macClr(macClr),
    .macBiasWriteEnable(macBiasWriteEnable)
  );

  // Synchronous-read memories; junk when not reading so gating is exercised.
  always @(posedge clk) begin
    if (rdEn) begin
      inData     <= act[rdAddr];
      weightData <= wrow[rdAddr];
    end else begin
      inData     <= IW'($urandom);
      weightData <= (NODES*WW)'($urandom);
    end
  end

  // multStore stand-in: bias load on clr+biasWE, otherwise MAC every edge.
  always @(posedge clk) begin
    for (int n = 0; n < NODES; n++) begin
      if (macClr && macBiasWriteEnable)
        acc[n] <= bias[n*BW +: BW];
      else
        acc[n] <= acc[n] + BW'(layer2In) * BW'(weightsOut[n*WW +: WW]);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] exp_sum(input int n);
    int s;
    s = int'(bias[n*BW +: BW]);
    for (int i = 0; i < N; i++) s += int'(act[i]) * int'(wrow[i][n*WW +: WW]);
    return BW'(s);
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < N; i++) begin
      act[i]  = IW'($urandom);
      wrow[i] = (NODES*WW)'($urandom);
    end
    bias = (NODES*BW)'($urandom);
  endtask

  // Cycle k of a pass (k=1 is LOAD) against the expected timeline.
  task automatic check_cycle(input int k);
    logic [31:0] e_l2;
    logic [31:0] e_w;
    chk("macClr", 32'(macClr), 32'(k == 1));
    chk("biasWE", 32'(macBiasWriteEnable), 32'(k == 1));
    chk("rdEn", 32'(rdEn), 32'(k >= 2 && k <= N + 1));
    chk("rdAddr", 32'(rdAddr), (k >= 2 && k <= N + 1) ? 32'(k - 2) : 32'd0);
    chk("busy", 32'(busy), 32'(k >= 1 && k <= N + 2));
    chk("done", 32'(done), 32'(k == N + 3));
    e_l2 = (k >= 3 && k <= N + 2) ? 32'(act[k-3])  : 32'd0;
    e_w  = (k >= 3 && k <= N + 2) ? 32'(wrow[k-3]) : 32'd0;
    chk("layer2In", 32'(layer2In), e_l2);
    chk("weightsOut", 32'(weightsOut), e_w);
  endtask

  task automatic check_idle();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_rdEn", 32'(rdEn), 32'd0);
    chk("idle_rdAddr", 32'(rdAddr), 32'd0);
    chk("idle_macClr", 32'(macClr), 32'd0);
    chk("idle_biasWE", 32'(macBiasWriteEnable), 32'd0);
    chk("idle_layer2In", 32'(layer2In), 32'd0);
    chk("idle_weightsOut", 32'(weightsOut), 32'd0);
  endtask

  // One pass; hold keeps start high throughout, pulse pokes start in RUN and DRAIN.
  task automatic run_pass(input bit hold, input bit pulse);
    fill_mem();
    start = 1'b1;
    for (int k = 1; k <= N + 3; k++) begin
      @(negedge clk);
      check_cycle(k);
      if (k == N + 3) begin
        for (int n = 0; n < NODES; n++) chk("sumOut", 32'(acc[n]), 32'(exp_sum(n)));
      end
      start = hold || (pulse && (k == 4 || k == N + 2));
    end
    if (!hold) begin
      @(negedge clk);
      check_idle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr   = 1'b1;
    start = 1'b0;
    fill_mem();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle();
    clr = 1'b0;
    @(negedge clk);
    check_idle();

    run_pass(1'b0, 1'b0);
    run_pass(1'b0, 1'b1);

    // start held high: passes recur every N+3 cycles, then release
    run_pass(1'b1, 1'b0);
    run_pass(1'b1, 1'b0);
    run_pass(1'b0, 1'b0);

    // clr in the second RUN cycle abandons the pass; clr beats start
    fill_mem();
    start = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check_cycle(k);
      start = 1'b0;
    end
    clr   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check_idle();
    clr   = 1'b0;
    start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_idle();
    end
    run_pass(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
